lgca_cell: RTL and testbench
============================

// Module: lgca_cell
// PURPOSE
//  Parametrised HPP lattice-gas cell, successor to the fixed 4-neighbour cell. It gathers
//  inbound particles from four neighbours and applies a mode-selectable collision rule:
//  HPP, random head-on, wall bounce-back or freeze. It supports inject/sink, step enable,
//  an internal seeded LFSR, and a windowed particle-density accumulator.
//  One instance per lattice site; the array wrapper wires each out to the neighbours' in_*.
// PARAMETERS
//  LFSR_W  16       LFSR width (8..32)
//  SEED    16'hACE1 LFSR reset value; must be non-zero; differs per instance in arrays
//  WINDOW  256      steps per density window (power of 2, >=2)
//  ACC_W   12       density accumulator width; must hold 4*WINDOW, else saturates
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       reset; asynchronous, active-low
//  step       in   1       advance the cell one lattice step this cycle
//  mode       in   2       00 HPP, 01 random, 10 wall, 11 freeze
//  in_n/e/s/w in   4 each  neighbour state vectors; bit d = particle moving in dir d
//  inject     in   4       OR'd into next state on a step (source)
//  sink       in   1       clears next state on a step; wins over inject
//  out        out  4       cell state; bit0 N, bit1 E, bit2 S, bit3 W
//  pop        out  3       popcount(out), 0..4
//  dens       out  ACC_W   particle total over the last completed window
//  dens_vld   out  1       1-cycle pulse when dens updates
// BEHAVIOUR
//  Reset (async assert, sync release): out=0, pop=0, dens=0, dens_vld=0, LFSR=SEED,
//   step counter=0, accumulator=0.
//  Arrival vector a = {in_e[3], in_n[2], in_w[1], in_s[0]}, i.e. particle moving N comes from S.
//  On a cycle with step=1, compute c from a by mode:
//   00 HPP: a=0101 -> 1010, a=1010 -> 0101, otherwise c=a.
//   01 random: head-on pairs as in HPP only if lfsr[LFSR_W-1]=1, else pass through;
//      all other vectors: c=a.
//   10 wall: bounce-back, c = {a[1],a[0],a[3],a[2]} (every particle reverses).
//   11 freeze: c = out (state held; accumulator and LFSR still advance).
//  next = sink ? 4'b0 : (c | inject); out <= next. Latency: one clock from inputs to out.
//  With step=0: out, LFSR, counter and accumulator hold; dens_vld=0.
//  pop is combinational from the out register and valid the same cycle as out.
//  LFSR: Fibonacci maximal-length taps for LFSR_W; shifts once per step. An all-zero state
//   is impossible from a non-zero SEED; if SEED=0, the LFSR forces to 1.
//  Density: on each step, acc += pop(next), saturating at 2^ACC_W-1; counter += 1.
//   On the step where counter wraps WINDOW-1 -> 0: dens <= final acc including that step,
//   dens_vld=1 on the next cycle, acc <= 0.
//  Mode and inject changes take effect on the next step; no pipelining of mode.
//  Asserting rst_n mid-window discards the partial accumulation; dens returns to 0.
// STRUCTURE
//  Shared pkg lgca_pkg: direction indices DIR_N=0..DIR_W=3, MODE_HPP/RAND/WALL/FREEZE
//   encodings, and the arrival-vector gather function (reused by boundary cells).
//  Sub-module lgca_lfsr #(W, SEED): enable, async active-low reset, parallel out.
//  Collision logic is a combinational case block; all registers live in lgca_cell.
// TESTING
//  1 Reset: rst_n low mid-run, no clk edge -> out=0, pop=0, dens=0 immediately.
//  2 HPP, step=1: in_s=1,in_n=4 (a=0101) -> out=1010, pop=2; a=0011 -> out=0011.
//  3 Random: a=1010 over 64 steps -> both 0101 and 1010 seen; sequence matches golden LFSR from SEED.
//  4 Wall: a=0001 -> out=0100; sink=1 with inject=1111 -> out=0000; mode 11 holds out.
//  5 Density: WINDOW=4, inject=1111 each step -> dens=16, dens_vld once per 4 steps.
//  6 Density gating: step low for 10 cycles in a window -> no dens_vld; dens unchanged.
//  6 Saturation: ACC_W=4, WINDOW=8, inject=1111 -> dens=15.

Source files
------------

// File: rtl/lgca_pkg.sv
// ----------------------------------------------------------------------------
// lgca_pkg
// Shared definitions for the HPP lattice-gas cell and its boundary variants:
//   - direction indices (bit d of a state vector = particle moving in dir d)
//   - collision mode encodings
//   - arrival-vector gather function
//   - 4-bit popcount helper
//   - Fibonacci maximal-length tap masks for LFSR widths 8..32
// ----------------------------------------------------------------------------
package lgca_pkg;

    localparam int unsigned DIR_N = 0;
    localparam int unsigned DIR_E = 1;
    localparam int unsigned DIR_S = 2;
    localparam int unsigned DIR_W = 3;

    typedef enum logic [1:0] {
        MODE_HPP    = 2'b00,
        MODE_RAND   = 2'b01,
        MODE_WALL   = 2'b10,
        MODE_FREEZE = 2'b11
    } mode_t;

    // The two head-on configurations that HPP rotates into each other.
    localparam logic [3:0] HEAD_NS = 4'b0101;
    localparam logic [3:0] HEAD_EW = 4'b1010;

    // A particle moving in direction d arrives from the neighbour on the
    // opposite side: N-movers come from S, E-movers from W, and so on.
    function automatic logic [3:0] gather(
        input logic [3:0] in_n,
        input logic [3:0] in_e,
        input logic [3:0] in_s,
        input logic [3:0] in_w
    );
        logic [3:0] a;
        a        = '0;
        a[DIR_N] = in_s[DIR_N];
        a[DIR_E] = in_w[DIR_E];
        a[DIR_S] = in_n[DIR_S];
        a[DIR_W] = in_e[DIR_W];
        return a;
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Tap masks for a left-shifting Fibonacci LFSR whose feedback enters
    // bit 0; mask bit (t-1) set for polynomial tap t.
    function automatic logic [31:0] lfsr_taps(input int unsigned w);
        logic [31:0] m;
        case (w)
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            14:      m = 32'h0000_2015;
            15:      m = 32'h0000_6000;
            16:      m = 32'h0000_D008;
            17:      m = 32'h0001_2000;
            18:      m = 32'h0002_0400;
            19:      m = 32'h0004_0023;
            20:      m = 32'h0009_0000;
            21:      m = 32'h0014_0000;
            22:      m = 32'h0030_0000;
            23:      m = 32'h0042_0000;
            24:      m = 32'h00E1_0000;
            25:      m = 32'h0120_0000;
            26:      m = 32'h0200_0023;
            27:      m = 32'h0400_0013;
            28:      m = 32'h0900_0000;
            29:      m = 32'h1400_0000;
            30:      m = 32'h2000_0029;
            31:      m = 32'h4800_0000;
            32:      m = 32'h8020_0003;
            default: m = 32'h0000_D008;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lgca_lfsr.sv
// ----------------------------------------------------------------------------
// lgca_lfsr
// Fibonacci maximal-length LFSR, shifts left once per enabled cycle.
// Ports:
//   clk    in   1   clock
//   rst_n  in   1   asynchronous active-low reset, loads SEED
//   en     in   1   advance one position this cycle
//   state  out  W   current register contents
// A zero SEED is replaced by 1 so the register never sits in the
// all-zero lock-up state.
// ----------------------------------------------------------------------------
module lgca_lfsr
    import lgca_pkg::*;
#(
    parameter int unsigned   W    = 16,
    parameter logic [W-1:0]  SEED = W'(16'hACE1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] state
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));
    localparam logic [W-1:0] INIT = (SEED == '0) ? W'(1) : SEED;

    logic fb;

    assign fb = ^(state & TAPS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
        end else if (en) begin
            // Recovery guard: a corrupted all-zero state would never leave.
            if (state == '0) begin
                state <= INIT;
            end else begin
                state <= {state[W-2:0], fb};
            end
        end
    end

endmodule

// File: rtl/lgca_cell.sv
// ----------------------------------------------------------------------------
// lgca_cell
// One HPP lattice-gas site. Gathers inbound particles from the four
// neighbours, applies a mode-selected collision rule, merges source/sink
// and registers the new state. A windowed accumulator reports the particle
// total over every WINDOW steps.
// Ports:
//   clk        in   1      clock
//   rst_n      in   1      asynchronous active-low reset (release expected
//                          to be synchronised upstream)
//   step       in   1      advance one lattice step this cycle
//   mode       in   2      00 HPP, 01 random head-on, 10 wall, 11 freeze
//   in_n/e/s/w in   4      neighbour state vectors
//   inject     in   4      OR'd into the next state on a step
//   sink       in   1      clears the next state on a step (beats inject)
//   out        out  4      cell state, bit0 N, bit1 E, bit2 S, bit3 W
//   pop        out  3      popcount(out)
//   dens       out  ACC_W  particle total over the last completed window
//   dens_vld   out  1      one-cycle pulse when dens updates
// ----------------------------------------------------------------------------
module lgca_cell
    import lgca_pkg::*;
#(
    parameter int unsigned        LFSR_W = 16,
    parameter logic [LFSR_W-1:0]  SEED   = LFSR_W'(16'hACE1),
    parameter int unsigned        WINDOW = 256,
    parameter int unsigned        ACC_W  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic [1:0]       mode,
    input  logic [3:0]       in_n,
    input  logic [3:0]       in_e,
    input  logic [3:0]       in_s,
    input  logic [3:0]       in_w,
    input  logic [3:0]       inject,
    input  logic             sink,
    output logic [3:0]       out,
    output logic [2:0]       pop,
    output logic [ACC_W-1:0] dens,
    output logic             dens_vld
);

    localparam int unsigned     CNT_W   = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WINDOW - 1);
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    mode_t             mode_sel;
    logic [3:0]        arr;
    logic [3:0]        coll;
    logic [3:0]        nxt;
    logic [2:0]        pop_nxt;
    logic [LFSR_W-1:0] lfsr;
    logic              coin;

    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W:0]    acc_sum;
    logic [ACC_W-1:0]  acc_sat;
    logic              wrap;

    // ------------------------------------------------------------------
    // Random source for the stochastic head-on rule
    // ------------------------------------------------------------------
    lgca_lfsr #(
        .W    (LFSR_W),
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (step),
        .state (lfsr)
    );

    assign coin     = lfsr[LFSR_W-1];
    assign mode_sel = mode_t'(mode);
    assign arr      = gather(in_n, in_e, in_s, in_w);

    // ------------------------------------------------------------------
    // Collision rule
    // ------------------------------------------------------------------
    always_comb begin
        coll = arr;
        case (mode_sel)
            MODE_HPP: begin
                if (arr == HEAD_NS) begin
                    coll = HEAD_EW;
                end else if (arr == HEAD_EW) begin
                    coll = HEAD_NS;
                end
            end
            MODE_RAND: begin
                if (coin && (arr == HEAD_NS)) begin
                    coll = HEAD_EW;
                end else if (coin && (arr == HEAD_EW)) begin
                    coll = HEAD_NS;
                end
            end
            MODE_WALL: begin
                // Every particle reverses: N<->S, E<->W.
                coll = {arr[DIR_E], arr[DIR_N], arr[DIR_W], arr[DIR_S]};
            end
            MODE_FREEZE: begin
                coll = out;
            end
            default: begin
                coll = arr;
            end
        endcase
    end

    assign nxt     = sink ? 4'b0000 : (coll | inject);
    assign pop_nxt = popcount4(nxt);
    assign pop     = popcount4(out);

    // ------------------------------------------------------------------
    // Density accumulation; the step that closes a window is included in
    // the reported total, and the accumulator restarts from zero.
    // ------------------------------------------------------------------
    assign acc_sum = {1'b0, acc} + (ACC_W + 1)'(pop_nxt);
    assign acc_sat = acc_sum[ACC_W] ? ACC_MAX : acc_sum[ACC_W-1:0];
    assign wrap    = (cnt == CNT_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out      <= '0;
            cnt      <= '0;
            acc      <= '0;
            dens     <= '0;
            dens_vld <= 1'b0;
        end else begin
            dens_vld <= 1'b0;
            if (step) begin
                out <= nxt;
                if (wrap) begin
                    cnt      <= '0;
                    acc      <= '0;
                    dens     <= acc_sat;
                    dens_vld <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                    acc <= acc_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_lgca_cell.sv
// ----------------------------------------------------------------------------
// tb_lgca_cell
// Scoreboard bench for lgca_cell. Two instances share all stimulus:
//   dut_a  WINDOW=4, ACC_W=12   (window/density behaviour)
//   dut_b  WINDOW=8, ACC_W=4    (accumulator saturation)
// Stimulus pushes expected state/density into queues; a monitor pops and
// compares whenever the DUT presents a new state or a dens_vld pulse.
// ----------------------------------------------------------------------------
module tb_lgca_cell;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step = 1'b0;
    logic       sink = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] in_n = '0, in_e = '0, in_s = '0, in_w = '0, inject = '0;

    logic [3:0]  out_a, out_b;
    logic [2:0]  pop_a, pop_b;
    logic [11:0] dens_a;
    logic [3:0]  dens_b;
    logic        vld_a, vld_b;

    always #5 clk = ~clk;

    lgca_cell #(.LFSR_W(16), .SEED(16'hACE1), .WINDOW(4), .ACC_W(12)) dut_a (
        .clk(clk), .rst_n(rst_n), .step(step), .mode(mode),
        .in_n(in_n), .in_e(in_e), .in_s(in_s), .in_w(in_w),
        .inject(inject), .sink(sink),
        .out(out_a), .pop(pop_a), .dens(dens_a), .dens_vld(vld_a)
    );

    lgca_cell #(.LFSR_W(16), .SEED(16'hACE1), .WINDOW(8), .ACC_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .step(step), .mode(mode),
        .in_n(in_n), .in_e(in_e), .in_s(in_s), .in_w(in_w),
        .inject(inject), .sink(sink),
        .out(out_b), .pop(pop_b), .dens(dens_b), .dens_vld(vld_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard queues and reference model ----------------
    typedef struct {
        string      name;
        logic [3:0] o;
        logic [2:0] p;
    } exp_t;

    exp_t oq[$];
    int   dq_a[$];
    int   dq_b[$];

    logic [15:0] m_lfsr;
    int m_acc_a, m_cnt_a, m_acc_b, m_cnt_b;

    function automatic void model_reset();
        m_lfsr  = 16'hACE1;
        m_acc_a = 0; m_cnt_a = 0;
        m_acc_b = 0; m_cnt_b = 0;
    endfunction

    // Issue one step with arrival vector a; non-gathered neighbour bits are
    // driven high so a wrong gather picks up stray particles.
    task automatic issue(input string name, input logic [1:0] md, input logic [3:0] a,
                         input logic [3:0] inj, input logic sk, input logic [3:0] exp_out);
        exp_t e;
        int   p;
        logic fb;
        mode   = md;
        in_s   = {3'b111, a[0]};
        in_w   = {2'b11, a[1], 1'b1};
        in_n   = {1'b1, a[2], 2'b11};
        in_e   = {a[3], 3'b111};
        inject = inj;
        sink   = sk;
        e.name = name;
        e.o    = exp_out;
        e.p    = 3'($countones(exp_out));
        oq.push_back(e);
        p = $countones(exp_out);
        fb = m_lfsr[15] ^ m_lfsr[14] ^ m_lfsr[12] ^ m_lfsr[3];
        m_lfsr = {m_lfsr[14:0], fb};
        m_acc_a = (m_acc_a + p > 4095) ? 4095 : m_acc_a + p;
        m_cnt_a++;
        if (m_cnt_a == 4) begin dq_a.push_back(m_acc_a); m_acc_a = 0; m_cnt_a = 0; end
        m_acc_b = (m_acc_b + p > 15) ? 15 : m_acc_b + p;
        m_cnt_b++;
        if (m_cnt_b == 8) begin dq_b.push_back(m_acc_b); m_acc_b = 0; m_cnt_b = 0; end
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
    endtask

    // ---------------------------- monitor ---------------------------------
    logic stepped = 1'b0;
    int seen_ns = 0, seen_ew = 0;
    int vcnt_a = 0, vcnt_b = 0;

    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            stepped = step;
            @(negedge clk);
            if (stepped) begin
                if (oq.size() == 0) begin
                    failures++;
                    $display("FAIL out_unexpected actual=%0h expected=none", out_a);
                end else begin
                    e = oq.pop_front();
                    chk({e.name, "_out_a"}, out_a, e.o);
                    chk({e.name, "_out_b"}, out_b, e.o);
                    chk({e.name, "_pop_a"}, pop_a, e.p);
                    chk({e.name, "_pop_b"}, pop_b, e.p);
                end
                if (out_a == 4'b0101) seen_ns++;
                if (out_a == 4'b1010) seen_ew++;
            end
            if (vld_a) begin
                vcnt_a++;
                if (dq_a.size() == 0) begin
                    failures++;
                    $display("FAIL dens_a_unexpected actual=%0d expected=none", dens_a);
                end else begin
                    chk("dens_a", dens_a, dq_a.pop_front());
                end
            end
            if (vld_b) begin
                vcnt_b++;
                if (dq_b.size() == 0) begin
                    failures++;
                    $display("FAIL dens_b_unexpected actual=%0d expected=none", dens_b);
                end else begin
                    chk("dens_b", dens_b, dq_b.pop_front());
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------- stimulus --------------------------------
    initial begin
        int va, vb;
        logic [3:0] ex;

        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out", out_a, 4'h0);
        chk("rst_pop", pop_a, 3'd0);
        chk("rst_dens", dens_a, 12'd0);
        chk("rst_vld", vld_a, 1'b0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // HPP collisions and pass-through
        issue("hpp_0101", 2'b00, 4'b0101, 4'b0000, 1'b0, 4'b1010);
        issue("hpp_0011", 2'b00, 4'b0011, 4'b0000, 1'b0, 4'b0011);
        issue("hpp_1010", 2'b00, 4'b1010, 4'b0000, 1'b0, 4'b0101);
        issue("hpp_1111", 2'b00, 4'b1111, 4'b0000, 1'b0, 4'b1111);
        issue("hpp_inj",  2'b00, 4'b0001, 4'b0100, 1'b0, 4'b0101);

        // Wall bounce-back, freeze, sink
        issue("wall_0001", 2'b10, 4'b0001, 4'b0000, 1'b0, 4'b0100);
        issue("wall_1001", 2'b10, 4'b1001, 4'b0000, 1'b0, 4'b0110);
        issue("frz_hold",  2'b11, 4'b1111, 4'b0000, 1'b0, 4'b0110);
        issue("frz_inj",   2'b11, 4'b0000, 4'b0001, 1'b0, 4'b0111);
        issue("sink",      2'b10, 4'b0101, 4'b1111, 1'b1, 4'b0000);
        drain();

        // Random head-on: decision follows the golden LFSR MSB from SEED
        do_reset();
        seen_ns = 0;
        seen_ew = 0;
        for (int i = 0; i < 64; i++) begin
            ex = m_lfsr[15] ? 4'b0101 : 4'b1010;
            issue("rand", 2'b01, 4'b1010, 4'b0000, 1'b0, ex);
        end
        drain();
        chk("rand_seen_0101", (seen_ns > 0), 1);
        chk("rand_seen_1010", (seen_ew > 0), 1);

        // Density windows and saturation
        do_reset();
        va = vcnt_a;
        vb = vcnt_b;
        for (int i = 0; i < 4; i++) issue("den_full", 2'b00, 4'b0000, 4'b1111, 1'b0, 4'b1111);
        drain();
        chk("dens_win4", dens_a, 12'd16);
        for (int i = 0; i < 4; i++) issue("den_full", 2'b00, 4'b0000, 4'b1111, 1'b0, 4'b1111);
        drain();
        chk("dens_win4_again", dens_a, 12'd16);
        chk("dens_sat", dens_b, 4'd15);
        chk("vld_pulses_a", vcnt_a - va, 2);
        chk("vld_pulses_b", vcnt_b - vb, 1);

        // Step gating inside a window
        issue("gate_pre", 2'b00, 4'b0000, 4'b0011, 1'b0, 4'b0011);
        issue("gate_pre", 2'b00, 4'b0000, 4'b0011, 1'b0, 4'b0011);
        va = vcnt_a;
        repeat (10) @(posedge clk);
        #1;
        chk("gate_no_vld", vcnt_a - va, 0);
        chk("gate_dens_held", dens_a, 12'd16);
        chk("gate_out_held", out_a, 4'b0011);
        issue("gate_post", 2'b00, 4'b0000, 4'b0001, 1'b0, 4'b0001);
        issue("gate_post", 2'b00, 4'b0000, 4'b0001, 1'b0, 4'b0001);
        drain();
        chk("gate_dens", dens_a, 12'd6);

        // Mid-window reset: immediate clear, partial sum discarded
        issue("pre_rst", 2'b00, 4'b0000, 4'b1111, 1'b0, 4'b1111);
        issue("pre_rst", 2'b00, 4'b0000, 4'b1111, 1'b0, 4'b1111);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out", out_a, 4'h0);
        chk("midrst_pop", pop_a, 3'd0);
        chk("midrst_dens_a", dens_a, 12'd0);
        chk("midrst_dens_b", dens_b, 4'd0);
        #1 rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) issue("post_rst", 2'b00, 4'b0000, 4'b0001, 1'b0, 4'b0001);
        drain();
        chk("post_rst_dens", dens_a, 12'd4);

        drain();
        chk("oq_empty", oq.size(), 0);
        chk("dq_a_empty", dq_a.size(), 0);
        chk("dq_b_empty", dq_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
